bitmap_draw_arbiter: RTL and testbench
======================================

// Module: bitmap_draw_arbiter
// PURPOSE
//  Merges pixel writes from NUM_CH parallel Julia-set iteration cores into the single bitmap
//  draw port of the VGA/SDRAM interface (draw, x, y, i). Round-robin arbitration feeds a FIFO,
//  which absorbs SDRAM write stalls. Replaces the single-core direct draw hookup.
// PARAMETERS
//  NUM_CH      4   number of iteration-core channels (1..16)
//  COORD_W     16  x/y coordinate width
//  ITER_W      8   iteration-count (colour index) width
//  FIFO_DEPTH  8   buffered pixels; power of two, >=2
//  H_RES       640 horizontal bound (used only with BOUNDS_CHECK_EN)
//  V_RES       480 vertical bound (used only with BOUNDS_CHECK_EN)
// PORTS
//  clk_clk        in   1                   system clock
//  reset_reset    in   1                   synchronous, active-high reset
//  ch_valid       in   NUM_CH              per-channel pixel valid
//  ch_ready       out  NUM_CH              per-channel accept (one-hot or zero)
//  ch_x           in   NUM_CH*COORD_W      packed x, channel k at [k*COORD_W +: COORD_W]
//  ch_y           in   NUM_CH*COORD_W      packed y
//  ch_i           in   NUM_CH*ITER_W       packed iteration count
//  draw           out  1                   pixel available to SDRAM writer
//  draw_ready     in   1                   SDRAM writer accepts pixel this cycle
//  draw_x/draw_y  out  COORD_W             head-of-FIFO coordinates
//  draw_i         out  ITER_W              head-of-FIFO iteration count
//  level          out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  busy           out  1                   any ch_valid high or FIFO non-empty
//  drop_count     out  16                  out-of-bounds pixels discarded (BOUNDS_CHECK_EN only)
// BEHAVIOUR
//  - Reset: FIFO pointers/level=0, draw=0, draw_x/y/i=0, rr pointer=channel 0, drop_count=0.
//  - Handshake (in): transfer when ch_valid[k]&&ch_ready[k]; channel holds data stable while
//    valid&&!ready. ch_ready is combinational: exactly the granted channel, only if push allowed.
//  - Arbitration: round-robin starting at rr pointer; after a transfer on channel k, pointer
//    moves to k+1 (mod NUM_CH). No transfer -> pointer unchanged. Max one accept per cycle.
//  - Push allowed when level<FIFO_DEPTH, or level==FIFO_DEPTH and a pop occurs same cycle.
//  - Output: show-ahead FIFO; draw = (level!=0); pop when draw&&draw_ready. draw_x/y/i valid
//    whenever draw=1, hold previous head value when empty (not X).
//  - Simultaneous push+pop: level unchanged; empty FIFO never bypasses (latency in->draw = 1 clk).
//  - Pointers wrap at FIFO_DEPTH; level saturates by construction, never exceeds FIFO_DEPTH.
//  - Reset mid-operation: FIFO contents discarded, in-flight channel handshakes abandoned;
//    ch_ready=0 during reset cycle.
// CONFIGURATION
//  BOUNDS_CHECK_EN defined: granted pixel with x>=H_RES or y>=V_RES is accepted (ch_ready=1)
//    but not pushed; drop_count increments, saturating at 16'hFFFF. Dropped pixel does not
//    require FIFO space and still advances rr pointer.
//  Not defined: all pixels pushed unchecked; drop_count tied to 0; H_RES/V_RES unused.
// STRUCTURE
//  Package jsv_draw_pkg: pixel_t struct {x,y,i} parametrised via localparams COORD_W/ITER_W
//    defaults, RR pointer width function, default H_RES/V_RES constants.
//  Sub-module draw_fifo: synchronous show-ahead FIFO (push/pop/level/full/empty) of pixel_t.
//  Arbiter + bounds check live in the top module.
// TESTING
//  1 Reset then idle -> draw=0, level=0, ch_ready=0, busy=0, drop_count=0.
//  2 All 4 channels valid continuously, draw_ready=1 -> grants 0,1,2,3,0...; draw output
//    pixels in same order, one per cycle after 1-cycle latency.
//  3 draw_ready=0, ch0 streams 10 pixels -> 8 accepted, level=8, ch_ready=0; raise draw_ready
//    -> remaining 2 accepted while full FIFO pops, order preserved.
//  4 Full FIFO, single cycle with push+pop -> level stays 8, head advances by one.
//  5 BOUNDS_CHECK_EN: ch1 sends (640,10),(5,480),(639,479) -> first two dropped, drop_count=2,
//    only (639,479) appears on draw. Without macro: all three appear, drop_count=0.
//  6 Reset asserted with level=5 -> next cycle level=0, draw=0, rr pointer at channel 0.

Source files
------------

// File: rtl/jsv_draw_pkg.sv
// Shared types and constants for the bitmap draw arbiter: default pixel record,
// default screen bounds and the round-robin pointer width helper.
package jsv_draw_pkg;

    localparam int PIX_COORD_W = 16;
    localparam int PIX_ITER_W  = 8;
    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;

    typedef struct packed {
        logic [PIX_COORD_W-1:0] x;
        logic [PIX_COORD_W-1:0] y;
        logic [PIX_ITER_W-1:0]  i;
    } pixel_t;

    // A single channel still needs a one-bit pointer register.
    function automatic int rr_ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/draw_fifo.sv
// Synchronous show-ahead pixel FIFO. The head is a register that keeps the last
// popped pixel when the FIFO drains, so the draw outputs never go undefined.
module draw_fifo
    import jsv_draw_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = pixel_t
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    T                   r_mem [DEPTH];
    T                   r_head;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;

    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_rd_next;
    T                   w_head_nxt;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_pop     = i_pop && !o_empty;
    assign w_push    = i_push && (!o_full || w_pop);
    assign w_rd_next = r_rd_ptr + PTR_W'(1);
    assign o_head    = r_head;
    assign o_level   = r_level;

    // Next head: following entry on pop, fresh data when the FIFO was (or becomes) empty.
    always_comb begin
        w_head_nxt = r_head;
        if (w_pop) begin
            if (r_level > LVL_W'(1)) begin
                w_head_nxt = r_mem[w_rd_next];
            end else if (w_push) begin
                w_head_nxt = i_data;
            end else begin
                w_head_nxt = r_head;
            end
        end else if (o_empty && w_push) begin
            w_head_nxt = i_data;
        end else begin
            w_head_nxt = r_head;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            r_head <= w_head_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/bitmap_draw_arbiter.sv
// Round-robin merge of NUM_CH iteration-core pixel streams into one draw port via a FIFO.
// Optional macro BOUNDS_CHECK_EN discards off-screen pixels and counts them in drop_count.
module bitmap_draw_arbiter
    import jsv_draw_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int COORD_W    = 16,
    parameter int ITER_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [NUM_CH-1:0]             ch_valid,
    output logic [NUM_CH-1:0]             ch_ready,
    input  logic [NUM_CH*COORD_W-1:0]     ch_x,
    input  logic [NUM_CH*COORD_W-1:0]     ch_y,
    input  logic [NUM_CH*ITER_W-1:0]      ch_i,
    output logic                          draw,
    input  logic                          draw_ready,
    output logic [COORD_W-1:0]            draw_x,
    output logic [COORD_W-1:0]            draw_y,
    output logic [ITER_W-1:0]             draw_i,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic [15:0]                   drop_count
);

    localparam int RR_W = rr_ptr_w(NUM_CH);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [ITER_W-1:0]  i;
    } pix_t;

    pix_t               w_ch_pix [NUM_CH];
    pix_t               w_pix;
    pix_t               w_head;
    logic [RR_W-1:0]    r_rr;
    logic [RR_W-1:0]    w_cand;
    logic [RR_W-1:0]    w_grant;
    logic               w_found;
    logic               w_oob;
    logic               w_pop;
    logic               w_accept;
    logic               w_push;
    logic               w_full;
    logic               w_empty;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign w_ch_pix[k] = {ch_x[k*COORD_W +: COORD_W], ch_y[k*COORD_W +: COORD_W],
                              ch_i[k*ITER_W +: ITER_W]};
    end

    // First valid channel searching upward from the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(r_rr) + k >= NUM_CH) begin
                w_cand = RR_W'(int'(r_rr) + k - NUM_CH);
            end else begin
                w_cand = RR_W'(int'(r_rr) + k);
            end
            if (!w_found && ch_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_pix = w_ch_pix[w_grant];

`ifdef BOUNDS_CHECK_EN
    assign w_oob = (w_pix.x >= COORD_W'(H_RES)) || (w_pix.y >= COORD_W'(V_RES));
`else
    assign w_oob = 1'b0;
`endif

    // A full FIFO can still take a pixel when its head leaves in the same cycle.
    assign w_pop    = !w_empty && draw_ready;
    assign w_accept = w_found && !reset_reset && (w_oob || !w_full || w_pop);
    assign w_push   = w_accept && !w_oob;

    // One-hot accept for the granted channel only.
    always_comb begin
        ch_ready = '0;
        if (w_accept) begin
            ch_ready[w_grant] = 1'b1;
        end else begin
            ch_ready = '0;
        end
    end

    // Round-robin pointer advances past the channel just served.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rr <= '0;
        end else if (w_accept) begin
            r_rr <= (w_grant == RR_W'(NUM_CH - 1)) ? '0 : w_grant + RR_W'(1);
        end else begin
            r_rr <= r_rr;
        end
    end

    draw_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (pix_t)
    ) u_fifo (
        .i_clk   (clk_clk),
        .i_srst  (reset_reset),
        .i_push  (w_push),
        .i_data  (w_pix),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign draw   = !w_empty;
    assign draw_x = w_head.x;
    assign draw_y = w_head.y;
    assign draw_i = w_head.i;
    assign busy   = (|ch_valid) || !w_empty;

`ifdef BOUNDS_CHECK_EN
    logic [15:0] r_drop;

    // Saturating count of discarded off-screen pixels.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_drop <= 16'h0000;
        end else if (w_accept && w_oob && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end else begin
            r_drop <= r_drop;
        end
    end

    assign drop_count = r_drop;
`else
    assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bitmap_draw_arbiter.sv
// Self-checking bench for bitmap_draw_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations. Honours BOUNDS_CHECK_EN.
module tb_bitmap_draw_arbiter;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int IW = 8;
    localparam int D  = 8;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [IW-1:0] i;
    } px_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    ch_valid = '0;
    logic [N-1:0]    ch_ready;
    logic [N*CW-1:0] ch_x = '0;
    logic [N*CW-1:0] ch_y = '0;
    logic [N*IW-1:0] ch_i = '0;
    logic            draw;
    logic            draw_ready = 1'b0;
    logic [CW-1:0]   draw_x;
    logic [CW-1:0]   draw_y;
    logic [IW-1:0]   draw_i;
    logic [3:0]      level;
    logic            busy;
    logic [15:0]     drop_count;

    int   total = 0;
    int   bad   = 0;
    px_t  src [N][$];
    px_t  mq[$];
    px_t  log_q[$];
    int   m_rr   = 0;
    px_t  m_last = '0;
    int   m_drop = 0;
    logic [N-1:0] acc = '0;

    bitmap_draw_arbiter #(
        .NUM_CH(N), .COORD_W(CW), .ITER_W(IW), .FIFO_DEPTH(D), .H_RES(640), .V_RES(480)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .ch_x        (ch_x),
        .ch_y        (ch_y),
        .ch_i        (ch_i),
        .draw        (draw),
        .draw_ready  (draw_ready),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_i      (draw_i),
        .level       (level),
        .busy        (busy),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit work_left();
        bit w = (mq.size() != 0);
        for (int k = 0; k < N; k++) if (src[k].size() != 0) w = 1'b1;
        return w;
    endfunction

    // Sources: retire the pixel accepted at the last edge, present the next one.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k] && src[k].size() != 0) void'(src[k].pop_front());
            if (src[k].size() != 0) begin
                ch_valid[k]          = 1'b1;
                ch_x[k*CW +: CW]     = src[k][0].x;
                ch_y[k*CW +: CW]     = src[k][0].y;
                ch_i[k*IW +: IW]     = src[k][0].i;
            end else begin
                ch_valid[k] = 1'b0;
            end
        end
    end

    // Reference model and per-cycle comparison.
    always @(negedge clk) begin
        int   g;
        int   kk;
        bit   found;
        bit   pop;
        bit   oob;
        bit   accept;
        logic [N-1:0] exp_rdy;
        px_t  cur;
        px_t  hd;
        found = 1'b0;
        g = 0;
        for (int o = 0; o < N; o++) begin
            kk = (m_rr + o) % N;
            if (!found && ch_valid[kk]) begin
                found = 1'b1;
                g = kk;
            end
        end
        cur.x = ch_x[g*CW +: CW];
        cur.y = ch_y[g*CW +: CW];
        cur.i = ch_i[g*IW +: IW];
        pop = (mq.size() != 0) && draw_ready;
`ifdef BOUNDS_CHECK_EN
        oob = (cur.x >= 16'd640) || (cur.y >= 16'd480);
`else
        oob = 1'b0;
`endif
        accept  = found && !rst && (oob || mq.size() < D || pop);
        exp_rdy = accept ? (N'(1) << g) : '0;
        hd      = (mq.size() != 0) ? mq[0] : m_last;

        check("ch_ready", 32'(ch_ready), 32'(exp_rdy));
        check("draw", 32'(draw), 32'(mq.size() != 0));
        check("level", 32'(level), 32'(mq.size()));
        check("busy", 32'(busy), 32'((ch_valid != '0) || (mq.size() != 0)));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        check("draw_x", 32'(draw_x), 32'(hd.x));
        check("draw_y", 32'(draw_y), 32'(hd.y));
        check("draw_i", 32'(draw_i), 32'(hd.i));

        acc = ch_valid & ch_ready;
        if (!rst && draw && draw_ready) log_q.push_back({draw_x, draw_y, draw_i});

        if (rst) begin
            mq.delete();
            m_rr   = 0;
            m_last = '0;
            m_drop = 0;
        end else begin
            if (pop) m_last = mq.pop_front();
            if (accept) begin
                if (oob) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq.push_back(cur);
                end
                m_rr = (g + 1) % N;
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int c = 0;
        while (work_left() && c < max_cyc) begin
            @(posedge clk);
            c++;
        end
        #2;
        check("drain_timeout", 32'(c < max_cyc), 32'd1);
    endtask

    initial begin
        int   mark;
        int   exp2 [8] = '{0, 100, 200, 300, 1, 101, 201, 301};
        px_t  p;

        // Reset and idle.
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_draw", 32'(draw), 32'd0);
        check("t1_level", 32'(level), 32'd0);
        check("t1_ready", 32'(ch_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_drop", 32'(drop_count), 32'd0);

        // All four channels stream together with the writer always ready.
        @(posedge clk);
        #2;
        for (int ch = 0; ch < N; ch++)
            for (int n = 0; n < 4; n++)
                src[ch].push_back('{x: 16'(ch*100 + n), y: 16'(10 + n), i: 8'(ch*16 + n)});
        draw_ready = 1'b1;
        mark = log_q.size();
        wait_drain(200);
        check("t2_count", 32'(log_q.size() - mark), 32'd16);
        for (int n = 0; n < 8; n++) check("t2_order", 32'(log_q[mark+n].x), 32'(exp2[n]));

        // Stalled writer: ch0 fills the FIFO, then one push+pop at full.
        draw_ready = 1'b0;
        mark = log_q.size();
        for (int n = 0; n < 10; n++) src[0].push_back('{x: 16'(1000 + n), y: 16'(n), i: 8'(n)});
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("t3_level", 32'(level), 32'd8);
        check("t3_ready", 32'(ch_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2 draw_ready = 1'b1;
        @(negedge clk);
        check("t4_ready", 32'(ch_ready), 32'd1);
        @(posedge clk);
        #2 draw_ready = 1'b0;
        @(negedge clk);
        check("t4_level", 32'(level), 32'd8);
        check("t4_head", 32'(draw_x), 32'd1001);
        @(posedge clk);
        #2 draw_ready = 1'b1;
        wait_drain(200);
        check("t3_count", 32'(log_q.size() - mark), 32'd10);
        for (int n = 0; n < 10 && mark + n < log_q.size(); n++)
            check("t3_order", 32'(log_q[mark+n].x), 32'(1000 + n));

        // Boundary pixels on ch1.
        mark = log_q.size();
        src[1].push_back('{x: 16'd640, y: 16'd10, i: 8'd1});
        src[1].push_back('{x: 16'd5, y: 16'd480, i: 8'd2});
        src[1].push_back('{x: 16'd639, y: 16'd479, i: 8'd3});
        wait_drain(100);
        repeat (2) @(posedge clk);
        @(negedge clk);
`ifdef BOUNDS_CHECK_EN
        check("t5_drop", 32'(drop_count), 32'd2);
        check("t5_count", 32'(log_q.size() - mark), 32'd1);
`else
        check("t5_drop", 32'(drop_count), 32'd0);
        check("t5_count", 32'(log_q.size() - mark), 32'd3);
`endif
        p = log_q[log_q.size()-1];
        check("t5_last_x", 32'(p.x), 32'd639);
        check("t5_last_y", 32'(p.y), 32'd479);

        // Reset with a partly full FIFO and the pointer parked at channel 3.
        @(posedge clk);
        #2 draw_ready = 1'b0;
        for (int n = 0; n < 5; n++) src[2].push_back('{x: 16'(2000 + n), y: 16'(n), i: 8'(n)});
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_level_pre", 32'(level), 32'd5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        src[1].push_back('{x: 16'd11, y: 16'd1, i: 8'd1});
        src[3].push_back('{x: 16'd33, y: 16'd3, i: 8'd3});
        @(negedge clk);
        check("t6_ready_in_reset", 32'(ch_ready), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        draw_ready = 1'b1;
        @(negedge clk);
        check("t6_level", 32'(level), 32'd0);
        check("t6_draw", 32'(draw), 32'd0);
        check("t6_rr", 32'(ch_ready), 32'd2);
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
